kim_fifo_rr_arbiter: RTL and testbench
======================================

KIM_FIFO_RR_ARBITER -- requirements
Module: kim_fifo_rr_arbiter

Interface
REQ-001 Parameter FIFO_DATA_LENGTH, default 32, SHALL set the data width of every stream.
REQ-002 Parameter ARB_BURST_MAX, default 4, range 1..255, SHALL set the maximum beats granted to one channel before re-arbitration.
REQ-003 The block SHALL have exactly 4 requester channels, ch0..ch3, with the 2-bit channel index ch0=0 through ch3=3.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  4  per-channel valid, bit n = chn.
REQ-007 s_ready  output  4  per-channel ready, bit n = chn.
REQ-008 s_data  input  4*FIFO_DATA_LENGTH  packed channel data, ch0 at the LSBs.
REQ-009 m_valid  output  1  valid toward the FIFO write port.
REQ-010 m_ready  input  1  ready from the FIFO write port.
REQ-011 m_data  output  FIFO_DATA_LENGTH  data of the granted channel.
REQ-012 m_ch  output  2  index of the granted channel.

Function
REQ-013 The block SHALL be a 2-state FSM, S_IDLE and S_LOCK, with registers rr_ptr[1:0], lock_ch[1:0] and beat_cnt[7:0].
REQ-014 In S_IDLE, sel SHALL be the first channel with s_valid high, searched in the order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
REQ-015 In S_IDLE with no s_valid bit high, sel SHALL equal rr_ptr, m_valid SHALL be 0 and the state SHALL not change.
REQ-016 In S_LOCK, sel SHALL equal lock_ch, and no other channel SHALL be considered.
REQ-017 The output path SHALL be combinational with zero latency: m_valid=s_valid[sel], m_data=s_data[sel], m_ch=sel.
REQ-018 Ready SHALL be combinational: s_ready[sel]=m_ready, and all other s_ready bits SHALL be 0.
REQ-019 A handshake SHALL be defined as m_valid && m_ready, and at most one beat SHALL transfer per cycle.
REQ-020 On a handshake in S_IDLE with ARB_BURST_MAX=1, the block SHALL set rr_ptr=sel+1 (mod 4) and stay in S_IDLE.
REQ-021 On a handshake in S_IDLE with ARB_BURST_MAX>1, the block SHALL set lock_ch=sel and beat_cnt=1, and move to S_LOCK.
REQ-022 On a handshake in S_LOCK with beat_cnt+1 < ARB_BURST_MAX, the block SHALL increment beat_cnt and stay in S_LOCK.
REQ-023 On a handshake in S_LOCK with beat_cnt+1 = ARB_BURST_MAX, the block SHALL move to S_IDLE, set rr_ptr=lock_ch+1 (mod 4) and clear beat_cnt.
REQ-024 In S_LOCK with s_valid[lock_ch]=0, the block SHALL move to S_IDLE, set rr_ptr=lock_ch+1 (mod 4) and clear beat_cnt (early release).
REQ-025 In S_LOCK with s_valid[lock_ch]=1 and m_ready=0, the state and all registers SHALL hold (FIFO full backpressure).
REQ-026 rr_ptr SHALL wrap from 3 to 0.
REQ-027 A change in another channel's s_valid SHALL never alter sel while in S_LOCK.

Reset
REQ-028 While rst=1, s_ready SHALL be 4'b0000 and m_valid SHALL be 0, regardless of m_ready.
REQ-029 After a clock edge with rst=1, the FSM SHALL be in S_IDLE with rr_ptr=0, lock_ch=0 and beat_cnt=0.
REQ-030 Reset asserted mid-burst SHALL abandon the lock, and the first arbitration after reset SHALL start from ch0.

Configuration
REQ-031 With macro KIM_FIFO_ARB_STAT_EN defined, the block SHALL add input cnt_clr (1 bit) and output grant_cnt (64 bits, 16 bits per channel, ch0 at the LSBs).
REQ-032 With KIM_FIFO_ARB_STAT_EN defined, each handshake SHALL increment grant_cnt[m_ch], the counter SHALL saturate at 16'hFFFF, and rst or cnt_clr SHALL clear all counters.
REQ-033 If cnt_clr and a handshake occur in the same cycle, the clear SHALL win.
REQ-034 Without KIM_FIFO_ARB_STAT_EN, the cnt_clr and grant_cnt ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 ARB_BURST_MAX=4, s_valid=4'b1111 held, m_ready=1: m_ch SHALL read 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0.
REQ-036 ARB_BURST_MAX=4, ch2 only valid for 2 beats then low: release after 2 beats, rr_ptr=3, and the next grant SHALL be ch3 if ch3 and ch0 both request.
REQ-037 In S_LOCK on ch1, m_ready=0 for 5 cycles while s_valid=4'b1111: m_ch SHALL stay 1, s_ready SHALL be 4'b0000, and beat_cnt SHALL hold.
REQ-038 ARB_BURST_MAX=1, s_valid=4'b1010, m_ready=1: m_ch SHALL alternate 1,3,1,3, with s_data routed and no beat lost or duplicated (scoreboard).
REQ-039 Assert rst during beat 2 of a ch3 burst: the cycle after reset, with s_valid=4'b1001, m_ch SHALL be 0.
REQ-040 With KIM_FIFO_ARB_STAT_EN defined, 70000 ch0 beats SHALL give grant_cnt[15:0]=16'hFFFF, and a cnt_clr pulse together with a handshake SHALL give 0.

Source files
------------

// File: rtl/kim_fifo_rr_arbiter.sv
// rtl/kim_fifo_rr_arbiter.sv - 4-channel round-robin burst arbiter feeding a FIFO write port
// Optional per-channel grant counters are enabled by defining KIM_FIFO_ARB_STAT_EN.
module kim_fifo_rr_arbiter #(
    parameter int FIFO_DATA_LENGTH = 32,
    parameter int ARB_BURST_MAX    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    s_valid,
    output logic [3:0]                    s_ready,
    input  logic [4*FIFO_DATA_LENGTH-1:0] s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [FIFO_DATA_LENGTH-1:0]   m_data,
    output logic [1:0]                    m_ch
`ifdef KIM_FIFO_ARB_STAT_EN
    ,
    input  logic                          cnt_clr,
    output logic [63:0]                   grant_cnt
`endif
);
    typedef enum logic {S_IDLE, S_LOCK} state_t;

    localparam logic [8:0] BURST_MAX = 9'(ARB_BURST_MAX);

    state_t                      state_q, state_d;
    logic [1:0]                  rr_ptr_q, rr_ptr_d;
    logic [1:0]                  lock_ch_q, lock_ch_d;
    logic [7:0]                  beat_cnt_q, beat_cnt_d;
    logic [1:0]                  sel;
    logic [1:0]                  cand;
    logic                        hs;
    logic [FIFO_DATA_LENGTH-1:0] ch_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign ch_data[g] = s_data[g*FIFO_DATA_LENGTH +: FIFO_DATA_LENGTH];
    end

    // Scan from the lowest priority upward so the highest-priority requester wins last.
    always_comb begin
        sel  = rr_ptr_q;
        cand = rr_ptr_q;
        if (state_q == S_LOCK) begin
            sel = lock_ch_q;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                cand = rr_ptr_q + 2'(i);
                if (s_valid[cand]) begin
                    sel = cand;
                end
            end
        end
    end

    assign m_valid = !rst && s_valid[sel];
    assign m_data  = ch_data[sel];
    assign m_ch    = sel;
    assign hs      = m_valid && m_ready;

    always_comb begin
        s_ready = 4'b0000;
        if (!rst) begin
            s_ready[sel] = m_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_ch_d  = lock_ch_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == S_IDLE) begin
            if (hs) begin
                if (ARB_BURST_MAX == 1) begin
                    rr_ptr_d = sel + 2'd1;
                end else begin
                    lock_ch_d  = sel;
                    beat_cnt_d = 8'd1;
                    state_d    = S_LOCK;
                end
            end
        end else begin
            // Owner dropping valid releases early; otherwise release on the final beat.
            if (!s_valid[lock_ch_q] || (hs && ({1'b0, beat_cnt_q} + 9'd1 >= BURST_MAX))) begin
                state_d    = S_IDLE;
                rr_ptr_d   = lock_ch_q + 2'd1;
                beat_cnt_d = 8'd0;
            end else if (hs) begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 2'd0;
            lock_ch_q  <= 2'd0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_ch_q  <= lock_ch_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef KIM_FIFO_ARB_STAT_EN
    logic [15:0] cnt_q [4];

    // Clear has priority over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst || cnt_clr) begin
                cnt_q[n] <= 16'd0;
            end else if (hs && sel == 2'(n) && cnt_q[n] != 16'hFFFF) begin
                cnt_q[n] <= cnt_q[n] + 16'd1;
            end
        end
    end

    assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_kim_fifo_rr_arbiter.sv
// tb/tb_kim_fifo_rr_arbiter.sv - randomized model-checked bench for kim_fifo_rr_arbiter (burst 4 and burst 1)
module tb_kim_fifo_rr_arbiter;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     s_valid;
    logic           m_ready;
    logic [4*W-1:0] s_data;
    logic [3:0]     s_ready4, s_ready1;
    logic           m_valid4, m_valid1;
    logic [W-1:0]   m_data4, m_data1;
    logic [1:0]     m_ch4, m_ch1;
`ifdef KIM_FIFO_ARB_STAT_EN
    logic           cnt_clr;
    logic [63:0]    grant_cnt4, grant_cnt1;
`endif

    always #5 clk = ~clk;

    kim_fifo_rr_arbiter #(.FIFO_DATA_LENGTH(W), .ARB_BURST_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_ch(m_ch4)
`ifdef KIM_FIFO_ARB_STAT_EN
        , .cnt_clr(cnt_clr), .grant_cnt(grant_cnt4)
`endif
    );

    kim_fifo_rr_arbiter #(.FIFO_DATA_LENGTH(W), .ARB_BURST_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_ch(m_ch1)
`ifdef KIM_FIFO_ARB_STAT_EN
        , .cnt_clr(cnt_clr), .grant_cnt(grant_cnt1)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: who owns the port (-1 = nobody), beats taken, and which channel has first priority.
    int owner [2];
    int beats [2];
    int prio  [2];
    int bmax  [2] = '{4, 1};

    logic         exp_valid [2];
    logic [1:0]   exp_ch    [2];
    logic [W-1:0] exp_data  [2];
    logic [3:0]   exp_ready [2];

    function automatic int model_sel(int k);
        if (owner[k] >= 0) return owner[k];
        for (int i = 0; i < 4; i++) begin
            if (s_valid[(prio[k] + i) % 4]) return (prio[k] + i) % 4;
        end
        return prio[k];
    endfunction

    task automatic drive(input logic r, input logic [3:0] v, input logic rdy);
        int c;
        rst     = r;
        s_valid = v;
        m_ready = rdy;
        s_data  = {$urandom, $urandom, $urandom, $urandom};
        #1;
        for (int k = 0; k < 2; k++) begin
            c            = model_sel(k);
            exp_ch[k]    = 2'(c);
            exp_valid[k] = !r && v[c];
            exp_data[k]  = s_data[c*W +: W];
            exp_ready[k] = r ? 4'b0000 : (4'(rdy) << c);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                owner[k] = -1; beats[k] = 0; prio[k] = 0;
            end else if (owner[k] >= 0) begin
                if (!s_valid[owner[k]]) begin
                    prio[k] = (owner[k] + 1) % 4; owner[k] = -1; beats[k] = 0;
                end else if (m_ready) begin
                    beats[k]++;
                    if (beats[k] >= bmax[k]) begin
                        prio[k] = (owner[k] + 1) % 4; owner[k] = -1; beats[k] = 0;
                    end
                end
            end else if (exp_valid[k] && m_ready) begin
                if (bmax[k] == 1) prio[k] = (int'(exp_ch[k]) + 1) % 4;
                else begin owner[k] = int'(exp_ch[k]); beats[k] = 1; end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        drive(1'b1, 4'b1111, 1'b1);
        total_cnt++;
        if ({m_valid4, m_valid1, s_ready4, s_ready1} !== 10'd0)
            $display("FAIL reset_outputs got v4=%b v1=%b r4=%b r1=%b want all 0", m_valid4, m_valid1, s_ready4, s_ready1);
        else pass_cnt++;
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        total_cnt++;
        if (m_valid4 !== 1'b0 || m_ch4 !== 2'd0 || m_ch1 !== 2'd0 || s_ready4 !== 4'b0001)
            $display("FAIL reset_state got v=%b ch4=%0d ch1=%0d r4=%b want v=0 ch=0 r=0001", m_valid4, m_ch4, m_ch1, s_ready4);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_rotation;
        drive(1'b1, 4'b0000, 1'b0); tick();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 4'b1111, 1'b1);
            total_cnt++;
            if (m_ch4 !== 2'((i / 4) % 4) || m_valid4 !== 1'b1 || m_data4 !== exp_data[0] || s_ready4 !== exp_ready[0])
                $display("FAIL rotation beat %0d got ch=%0d v=%b want ch=%0d v=1", i, m_ch4, m_valid4, (i / 4) % 4);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_early_release;
        drive(1'b1, 4'b0000, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0100, 1'b1);
            total_cnt++;
            if (m_ch4 !== 2'd2 || m_valid4 !== 1'b1)
                $display("FAIL early_release_beat%0d got ch=%0d v=%b want ch=2 v=1", i, m_ch4, m_valid4);
            else pass_cnt++;
            tick();
        end
        drive(1'b0, 4'b1001, 1'b1);
        total_cnt++;
        if (m_valid4 !== 1'b0 || m_ch4 !== 2'd2)
            $display("FAIL early_release_drop got ch=%0d v=%b want ch=2 v=0", m_ch4, m_valid4);
        else pass_cnt++;
        tick();
        drive(1'b0, 4'b1001, 1'b1);
        total_cnt++;
        if (m_ch4 !== 2'd3 || m_valid4 !== 1'b1)
            $display("FAIL early_release_next got ch=%0d v=%b want ch=3 v=1", m_ch4, m_valid4);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure;
        drive(1'b1, 4'b0000, 1'b0); tick();
        drive(1'b0, 4'b0010, 1'b1);
        total_cnt++;
        if (m_ch4 !== 2'd1) $display("FAIL backpressure_lock got ch=%0d want 1", m_ch4);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, 1'b0);
            total_cnt++;
            if (m_ch4 !== 2'd1 || s_ready4 !== 4'b0000 || m_valid4 !== 1'b1)
                $display("FAIL backpressure_hold %0d got ch=%0d r=%b v=%b want ch=1 r=0000 v=1", i, m_ch4, s_ready4, m_valid4);
            else pass_cnt++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b1111, 1'b1);
            total_cnt++;
            if (m_ch4 !== ((i < 3) ? 2'd1 : 2'd2))
                $display("FAIL backpressure_resume %0d got ch=%0d want %0d", i, m_ch4, (i < 3) ? 1 : 2);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_burst1;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] obs_q[$];
        drive(1'b1, 4'b0000, 1'b0); tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'b1010, 1'b1);
            exp_q.push_back(s_data[((i % 2 == 0) ? 1 : 3)*W +: W]);
            if (m_valid1 && m_ready) obs_q.push_back(m_data1);
            total_cnt++;
            if (m_ch1 !== ((i % 2 == 0) ? 2'd1 : 2'd3))
                $display("FAIL burst1_alternate %0d got ch=%0d want %0d", i, m_ch1, (i % 2 == 0) ? 1 : 3);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL burst1_beat_count got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL burst1_data %0d got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_burst;
        drive(1'b1, 4'b0000, 1'b0); tick();
        drive(1'b0, 4'b1000, 1'b1);
        total_cnt++;
        if (m_ch4 !== 2'd3) $display("FAIL mid_reset_lock got ch=%0d want 3", m_ch4);
        else pass_cnt++;
        tick();
        drive(1'b1, 4'b1000, 1'b1);
        total_cnt++;
        if (m_valid4 !== 1'b0 || s_ready4 !== 4'b0000)
            $display("FAIL mid_reset_gate got v=%b r=%b want v=0 r=0000", m_valid4, s_ready4);
        else pass_cnt++;
        tick();
        drive(1'b0, 4'b1001, 1'b1);
        total_cnt++;
        if (m_ch4 !== 2'd0 || m_ch1 !== 2'd0 || m_valid4 !== 1'b1)
            $display("FAIL mid_reset_restart got ch4=%0d ch1=%0d v=%b want 0 0 1", m_ch4, m_ch1, m_valid4);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random;
        logic       r;
        logic [3:0] v;
        logic       rdy;
        drive(1'b1, 4'b0000, 1'b0); tick();
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            v   = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            drive(r, v, rdy);
            total_cnt++;
            if ({m_valid4, m_ch4, m_data4, s_ready4} !== {exp_valid[0], exp_ch[0], exp_data[0], exp_ready[0]})
                $display("FAIL random_b4 cyc %0d got v=%b ch=%0d r=%b want v=%b ch=%0d r=%b", i, m_valid4, m_ch4, s_ready4, exp_valid[0], exp_ch[0], exp_ready[0]);
            else pass_cnt++;
            total_cnt++;
            if ({m_valid1, m_ch1, m_data1, s_ready1} !== {exp_valid[1], exp_ch[1], exp_data[1], exp_ready[1]})
                $display("FAIL random_b1 cyc %0d got v=%b ch=%0d r=%b want v=%b ch=%0d r=%b", i, m_valid1, m_ch1, s_ready1, exp_valid[1], exp_ch[1], exp_ready[1]);
            else pass_cnt++;
            tick();
        end
    endtask

`ifdef KIM_FIFO_ARB_STAT_EN
    task automatic test_stats;
        cnt_clr = 1'b0;
        drive(1'b1, 4'b0000, 1'b0); tick();
        drive(1'b0, 4'b0000, 1'b0);
        total_cnt++;
        if (grant_cnt4 !== 64'd0) $display("FAIL stat_reset got %h want 0", grant_cnt4);
        else pass_cnt++;
        for (int i = 0; i < 70000; i++) begin
            drive(1'b0, 4'b0001, 1'b1);
            tick();
        end
        drive(1'b0, 4'b0000, 1'b0);
        total_cnt++;
        if (grant_cnt4 !== 64'h0000_0000_0000_FFFF || grant_cnt1 !== 64'h0000_0000_0000_FFFF)
            $display("FAIL stat_saturate got b4=%h b1=%h want 000000000000ffff", grant_cnt4, grant_cnt1);
        else pass_cnt++;
        drive(1'b0, 4'b0001, 1'b1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        drive(1'b0, 4'b0000, 1'b0);
        total_cnt++;
        if (grant_cnt4 !== 64'd0) $display("FAIL stat_clear_wins got %h want 0", grant_cnt4);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0100, 1'b1);
            tick();
        end
        drive(1'b0, 4'b0000, 1'b0);
        total_cnt++;
        if (grant_cnt4 !== 64'h0000_0003_0000_0000) $display("FAIL stat_count_ch2 got %h want 0000000300000000", grant_cnt4);
        else pass_cnt++;
    endtask
`endif

    initial begin
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; beats[k] = 0; prio[k] = 0;
        end
`ifdef KIM_FIFO_ARB_STAT_EN
        cnt_clr = 1'b0;
`endif
        test_reset();
        test_rotation();
        test_early_release();
        test_backpressure();
        test_burst1();
        test_reset_mid_burst();
        test_random();
`ifdef KIM_FIFO_ARB_STAT_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
